// File: rtl/pixel_fifo_reader.sv
// rtl/pixel_fifo_reader.sv - rasterizer pixel FIFO consumer writing pixels to framebuffer SRAM
//
// Pops 96-bit pixel packets, decodes x/y/RGB666 and writes each pixel to
// framebuffer address y*H_RES+x over a req/ack handshake. Emits frame_done
// once the rasterizer is idle and every queued pixel has been retired.
// Build option: PIXEL_BOUNDS_CHECK_EN drops off-screen packets and adds clip_count.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   rd_data, empty     FIFO read data (valid the cycle after rd_en), FIFO empty flag
//   rd_en              FIFO pop strobe
//   raster_ready       rasterizer idle between triangles
//   fifo_ready         reader accepting packets
//   mem_req, mem_addr, mem_wdata, mem_ack   framebuffer write handshake
//   frame_done         single-cycle completion pulse
//   clip_count         dropped packet count (PIXEL_BOUNDS_CHECK_EN builds only)
//   pixel_count        pixels written since reset
module pixel_fifo_reader #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int COL_LEN  = 10,
  parameter int LINE_LEN = 9,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [95:0]       rd_data,
  input  logic              empty,
  output logic              rd_en,
  input  logic              raster_ready,
  output logic              fifo_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [17:0]       mem_wdata,
  input  logic              mem_ack,
  output logic              frame_done,
`ifdef PIXEL_BOUNDS_CHECK_EN
  output logic [15:0]       clip_count,
`endif
  output logic [31:0]       pixel_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  // FETCH takes two cycles: phase 0 captures rd_data, phase 1 forms the address.
  logic                fetch_phase_q, fetch_phase_d;
  logic [COL_LEN-1:0]  x_q, x_d;
  logic [LINE_LEN-1:0] y_q, y_d;
  logic [17:0]         rgb_q, rgb_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [17:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         pixel_count_q, pixel_count_d;
  logic                pending_q, pending_d;
  logic                fifo_ready_q;
`ifdef PIXEL_BOUNDS_CHECK_EN
  logic [15:0]         clip_count_q, clip_count_d;
`endif

  logic [31:0]         addr_full;
  logic                in_bounds;
  logic                unused_bits;

  assign addr_full = 32'(y_q) * 32'(H_RES) + 32'(x_q);

`ifdef PIXEL_BOUNDS_CHECK_EN
  assign in_bounds = (32'(x_q) < 32'(H_RES)) && (32'(y_q) < 32'(V_RES));
`else
  assign in_bounds = 1'b1;
`endif

  // Packet bits outside the decoded fields and the address bits above ADDR_W.
  assign unused_bits = ^{rd_data[95:89], rd_data[79:74], rd_data[63:56],
                         rd_data[49:48], rd_data[41:40], rd_data[33:0],
                         addr_full[31:ADDR_W], 32'(V_RES)};

  always_comb begin
    state_d       = state_q;
    fetch_phase_d = fetch_phase_q;
    x_d           = x_q;
    y_d           = y_q;
    rgb_d         = rgb_q;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    pixel_count_d = pixel_count_q;
    pending_d     = pending_q;
`ifdef PIXEL_BOUNDS_CHECK_EN
    clip_count_d  = clip_count_q;
`endif
    rd_en         = 1'b0;
    frame_done    = 1'b0;

    // rd_en and frame_done are combinational, so hold them low while in reset.
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (!empty) begin
            // A pop takes priority over a simultaneous frame_done condition.
            rd_en         = 1'b1;
            fetch_phase_d = 1'b0;
            state_d       = FETCH;
          end else if (raster_ready && pending_q) begin
            frame_done = 1'b1;
            pending_d  = 1'b0;
          end
        end

        FETCH: begin
          if (!fetch_phase_q) begin
            x_d           = rd_data[64 +: COL_LEN];
            y_d           = rd_data[80 +: LINE_LEN];
            rgb_d         = {rd_data[55:50], rd_data[47:42], rd_data[39:34]};
            fetch_phase_d = 1'b1;
          end else begin
            fetch_phase_d = 1'b0;
            if (in_bounds) begin
              mem_addr_d  = addr_full[ADDR_W-1:0];
              mem_wdata_d = rgb_q;
              mem_req_d   = 1'b1;
              state_d     = WRITE;
            end else begin
`ifdef PIXEL_BOUNDS_CHECK_EN
              clip_count_d = clip_count_q + 16'd1;
`endif
              state_d = IDLE;
            end
          end
        end

        WRITE: begin
          if (mem_ack) begin
            mem_req_d     = 1'b0;
            pixel_count_d = pixel_count_q + 32'd1;
            pending_d     = 1'b1;
            state_d       = IDLE;
          end
        end

        default: begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      fetch_phase_q <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= '0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      pixel_count_q <= '0;
      pending_q     <= 1'b0;
      fifo_ready_q  <= 1'b0;
`ifdef PIXEL_BOUNDS_CHECK_EN
      clip_count_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      fetch_phase_q <= fetch_phase_d;
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      pixel_count_q <= pixel_count_d;
      pending_q     <= pending_d;
      fifo_ready_q  <= 1'b1;
`ifdef PIXEL_BOUNDS_CHECK_EN
      clip_count_q  <= clip_count_d;
`endif
    end
  end

  assign fifo_ready  = fifo_ready_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign pixel_count = pixel_count_q;
`ifdef PIXEL_BOUNDS_CHECK_EN
  assign clip_count  = clip_count_q;
`endif

endmodule

// File: tb/tb_pixel_fifo_reader.sv
// tb/tb_pixel_fifo_reader.sv - directed self-checking bench for pixel_fifo_reader
module tb_pixel_fifo_reader;

  localparam int ADDR_W = 19;

  logic              clk = 1'b0;
  logic              rst;
  logic [95:0]       rd_data;
  logic              empty;
  logic              rd_en;
  logic              raster_ready;
  logic              fifo_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [17:0]       mem_wdata;
  logic              mem_ack;
  logic              frame_done;
  logic [31:0]       pixel_count;
`ifdef PIXEL_BOUNDS_CHECK_EN
  logic [15:0]       clip_count;
`endif

  pixel_fifo_reader dut (
    .clk          (clk),
    .rst          (rst),
    .rd_data      (rd_data),
    .empty        (empty),
    .rd_en        (rd_en),
    .raster_ready (raster_ready),
    .fifo_ready   (fifo_ready),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ack      (mem_ack),
    .frame_done   (frame_done),
`ifdef PIXEL_BOUNDS_CHECK_EN
    .clip_count   (clip_count),
`endif
    .pixel_count  (pixel_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [95:0] fifo_q[$];

  // Event monitor sampled on the falling edge.
  int mon_pops     = 0;
  int mon_bad_pops = 0;
  int mon_req_cyc  = 0;
  int mon_fd       = 0;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [17:0]       wr_data_log[$];

  always @(negedge clk) begin
    if (rd_en) mon_pops++;
    if (rd_en && empty) mon_bad_pops++;
    if (mem_req) mon_req_cyc++;
    if (mem_req && mem_ack) begin
      wr_addr_log.push_back(mem_addr);
      wr_data_log.push_back(mem_wdata);
    end
    if (frame_done) mon_fd++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock: FIFO pops on the edge where rd_en was high; data shows up just after.
  task automatic cycle();
    logic pop;
    @(negedge clk);
    pop = rd_en;
    @(posedge clk);
    #1;
    if (pop && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
    empty = (fifo_q.size() == 0);
    #1;
  endtask

  task automatic push(input logic [95:0] p);
    fifo_q.push_back(p);
    empty = 1'b0;
    #1;
  endtask

  function automatic logic [95:0] make_pkt(input int x, input int y,
                                           input logic [5:0] r, input logic [5:0] g,
                                           input logic [5:0] b);
    logic [95:0] p;
    p = '0;
    p[88:80] = y[8:0];
    p[73:64] = x[9:0];
    p[55:50] = r;
    p[47:42] = g;
    p[39:34] = b;
    return p;
  endfunction

  initial begin
    logic [95:0] ref_pkt;
    logic [95:0] ign_mask;
    logic        stable;
    logic        popped;
    int          base_pops, base_req, base_fd, base_log;

    rst          = 1'b1;
    rd_data      = '0;
    empty        = 1'b1;
    raster_ready = 1'b0;
    mem_ack      = 1'b1;
    ref_pkt      = 96'h00030005_00A854FC_00000000;
    ign_mask     = ~make_pkt(1023, 511, 6'h3F, 6'h3F, 6'h3F);

    // Reset state
    repeat (3) cycle();
    check("rst_rd_en", rd_en, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_pixel_count", pixel_count, 0);
    check("rst_fifo_ready", fifo_ready, 0);
    rst = 1'b0;
    repeat (2) cycle();
    check("fifo_ready_up", fifo_ready, 1);

    // Single pixel, zero-wait ack, 3-cycle latency
    base_pops = mon_pops;
    base_req  = mon_req_cyc;
    push(ref_pkt);
    check("single_pop", rd_en, 1);
    cycle();
    check("single_c1_req", mem_req, 0);
    check("single_c1_pop", rd_en, 0);
    cycle();
    check("single_c2_req", mem_req, 0);
    cycle();
    check("single_c3_req", mem_req, 1);
    check("single_addr", mem_addr, 1925);
    check("single_wdata", mem_wdata, 18'h2A57F);
    cycle();
    check("single_req_drop", mem_req, 0);
    check("single_count", pixel_count, 1);
    repeat (4) cycle();
    check("single_pop_count", mon_pops - base_pops, 1);
    check("single_req_cycles", mon_req_cyc - base_req, 1);

    // Ack stall: 6 cycles of stable request, no pop while stalled
    mem_ack = 1'b0;
    push(ref_pkt);
    repeat (3) cycle();
    check("stall_req_rise", mem_req, 1);
    push(make_pkt(10, 20, 6'h01, 6'h02, 6'h03));
    stable = (mem_req === 1'b1) && (mem_addr === 19'd1925) && (mem_wdata === 18'h2A57F);
    popped = rd_en;
    for (int i = 0; i < 5; i++) begin
      cycle();
      if (!((mem_req === 1'b1) && (mem_addr === 19'd1925) && (mem_wdata === 18'h2A57F)))
        stable = 1'b0;
      if (rd_en) popped = 1'b1;
    end
    check("stall_stable", stable, 1);
    check("stall_no_pop", popped, 0);
    mem_ack = 1'b1;
    cycle();
    check("stall_req_drop", mem_req, 0);
    check("stall_count", pixel_count, 2);
    check("stall_next_pop", rd_en, 1);
    repeat (6) cycle();
    check("stall_second_count", pixel_count, 3);
    check("stall_second_addr", wr_addr_log[wr_addr_log.size()-1], 12810);
    check("stall_second_wdata", wr_data_log[wr_data_log.size()-1], 18'h01083);

    // Reset while in WRITE
    mem_ack = 1'b0;
    push(ref_pkt);
    repeat (3) cycle();
    check("rstw_req_before", mem_req, 1);
    rst = 1'b1;
    #1;
    check("rstw_rd_en_now", rd_en, 0);
    cycle();
    check("rstw_req", mem_req, 0);
    check("rstw_count", pixel_count, 0);
    check("rstw_fifo_ready", fifo_ready, 0);
    push(ref_pkt);
    check("rstw_no_pop", rd_en, 0);
    cycle();
    check("rstw_no_pop2", rd_en, 0);
    fifo_q.delete();
    empty   = 1'b1;
    rst     = 1'b0;
    mem_ack = 1'b1;
    repeat (2) cycle();
    check("rstw_fifo_ready_up", fifo_ready, 1);
    check("rstw_no_frame_done", mon_fd, 0);

    // Burst of 4 on the last line, ignored packet bits all set
    base_pops = mon_pops;
    base_log  = wr_addr_log.size();
    for (int i = 0; i < 4; i++)
      fifo_q.push_back(make_pkt(i, 479, 6'(i), 6'(32 + i), 6'(63 - i)) | ign_mask);
    push(make_pkt(4, 479, 6'h00, 6'h00, 6'h00) & 96'h0);
    void'(fifo_q.pop_back());
    empty = (fifo_q.size() == 0);
    #1;
    repeat (25) cycle();
    check("burst_pops", mon_pops - base_pops, 4);
    check("burst_writes", wr_addr_log.size() - base_log, 4);
    check("burst_count", pixel_count, 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("burst_addr%0d", i), wr_addr_log[base_log + i], 306560 + i);
      check($sformatf("burst_wdata%0d", i), wr_data_log[base_log + i],
            {6'(i), 6'(32 + i), 6'(63 - i)});
    end

    // frame_done: one pulse, never repeated while idle
    base_fd = mon_fd;
    raster_ready = 1'b1;
    repeat (2) cycle();
    check("fd_pulse", mon_fd - base_fd, 1);
    repeat (20) cycle();
    check("fd_no_repeat", mon_fd - base_fd, 1);

    // Pop wins over a simultaneous frame_done condition
    raster_ready = 1'b0;
    push(make_pkt(7, 8, 6'h11, 6'h22, 6'h33));
    repeat (6) cycle();
    check("sim_count", pixel_count, 5);
    base_fd = mon_fd;
    raster_ready = 1'b1;
    push(make_pkt(9, 1, 6'h05, 6'h06, 6'h07));
    check("sim_fd_suppressed", frame_done, 0);
    check("sim_pop", rd_en, 1);
    repeat (8) cycle();
    check("sim_count2", pixel_count, 6);
    check("sim_fd_after", mon_fd - base_fd, 1);
    check("sim_addr", wr_addr_log[wr_addr_log.size()-1], 649);

`ifdef PIXEL_BOUNDS_CHECK_EN
    // Off-screen packet dropped, then bottom-right corner written
    base_req = mon_req_cyc;
    push(make_pkt(700, 10, 6'h01, 6'h01, 6'h01));
    repeat (8) cycle();
    check("clip_count", clip_count, 1);
    check("clip_no_req", mon_req_cyc - base_req, 0);
    check("clip_pixel_count", pixel_count, 6);
    push(make_pkt(639, 479, 6'h3F, 6'h00, 6'h3F));
    repeat (8) cycle();
    check("corner_addr", wr_addr_log[wr_addr_log.size()-1], 307199);
    check("corner_count", pixel_count, 7);
    check("corner_clip", clip_count, 1);
`endif

    check("never_pop_empty", mon_bad_pops, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pixel_fifo_reader.md
Name: pixel_fifo_reader

Overview:
- Read-side consumer of the rasterizer pixel FIFO. Pops 96-bit pixel packets, decodes x/y/RGB666, and writes each pixel into the framebuffer SRAM at linear address y*H_RES+x over a req/ack handshake.
- Drives `fifo_ready` back to the rasterizer.
- Emits a `frame_done` pulse once the rasterizer is idle and every queued pixel has been retired.

Parameters:
- H_RES, 640, framebuffer width in pixels; linear address stride.
- V_RES, 480, framebuffer height in pixels.
- COL_LEN, 10, x field width.
- LINE_LEN, 9, y field width.
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_data  in  96  FIFO read data; valid the cycle after rd_en.
- empty  in  1  FIFO empty flag.
- rd_en  out  1  FIFO pop strobe.
- raster_ready  in  1  rasterizer idle (between triangles).
- fifo_ready  out  1  reader accepting packets (high whenever not in reset).
- mem_req  out  1  framebuffer write request.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  18  pixel data {r[5:0], g[5:0], b[5:0]}.
- mem_ack  in  1  SRAM accepted the write (sampled while mem_req is high).
- frame_done  out  1  single-cycle completion pulse.
- pixel_count  out  32  pixels written since reset; wraps at 2^32.

Behaviour:
- Packet decode:
  - y = rd_data[88:80]
  - x = rd_data[73:64]
  - r = rd_data[55:50], g = rd_data[47:42], b = rd_data[39:34]
  - All other bits ignored.
- Reset values: rd_en=0, mem_req=0, mem_addr=0, mem_wdata=0, frame_done=0, pixel_count=0, fifo_ready=0, state=IDLE, pending=0.
- fifo_ready is 1 from the first cycle after rst deasserts.
- States:
  - IDLE: if !empty, assert rd_en for exactly one cycle and go to FETCH. Otherwise rd_en=0.
  - FETCH: rd_en=0. Latch decoded fields, compute mem_addr = y*H_RES + x (truncated to ADDR_W), mem_wdata={r,g,b}, then go to WRITE.
  - WRITE: hold mem_req=1 with mem_addr/mem_wdata stable until mem_ack=1 is sampled. On that edge: mem_req<=0, pixel_count+=1, pending<=1, go to IDLE.
- Latency and throughput:
  - empty low to mem_req high: 3 cycles.
  - Minimum 4 cycles per pixel with a zero-wait mem_ack (ack in the first WRITE cycle).
- rd_en is never asserted while empty=1 or outside IDLE.
- mem_ack outside WRITE is ignored.
- frame_done:
  - Pulses high for one cycle when state=IDLE, empty=1, raster_ready=1 and pending=1; the pulse clears pending.
  - Without pending, no pulse is generated, so an idle system never repeats frame_done.
- Simultaneous events: empty falling in the same cycle the frame_done conditions would hold suppresses frame_done; the pop wins.
- Reset mid-WRITE: mem_req drops on the next edge. The in-flight pixel is discarded and not counted.
- Arithmetic: the address multiply may be a constant shift-add; the result must equal y*H_RES+x exactly for all x<2^COL_LEN and y<2^LINE_LEN, modulo 2^ADDR_W.

Optional Feature:
- Macro: PIXEL_BOUNDS_CHECK_EN.
- Defined:
  - In FETCH, a packet with x>=H_RES or y>=V_RES is dropped. No mem_req, no pixel_count increment; return directly to IDLE.
  - A 16-bit output `clip_count` (reset 0, wraps) increments per dropped packet.
  - Dropped packets do not set pending.
- Undefined:
  - Every packet is written.
  - `clip_count` port is absent.

Test Plan:
- Single pixel: rd_data=96'h00030005_00A854FC_00000000 (x=5, y=3, r=2A, g=15, b=3F), mem_ack tied high -> one rd_en pulse; mem_req for 1 cycle with mem_addr=1925, mem_wdata=18'h2A57F; pixel_count=1.
- Ack stall: same packet, mem_ack held low 5 cycles after mem_req rises -> mem_req, mem_addr and mem_wdata stable for 6 cycles; no second rd_en while stalled even though empty=0.
- Burst of 4 packets (x=0..3, y=479), ack tied high -> addresses 306560..306563 in order; rd_en high exactly 4 times and never while empty=1; pixel_count=4.
- frame_done: after the burst, raster_ready=1 and empty=1 -> exactly one frame_done pulse. Hold conditions 20 more cycles -> no further pulse.
- Reset in WRITE: assert rst with mem_req=1 -> mem_req=0 the following cycle, pixel_count=0, rd_en=0, fifo_ready=0 during reset.
- With PIXEL_BOUNDS_CHECK_EN: packet x=700, y=10 -> no mem_req, clip_count=1, pixel_count unchanged. Next packet x=639, y=479 is written at address 307199.
